iopmp_entry_cfg: RTL and testbench

- Programming-side register file for the IOPMP entry table: the writer for the per-entry address matchers.
- Accepts single-beat read/write requests over a valid/ready handshake from the IOPMP register front-end.
- Stores legalized address and cfg registers for every entry, enforces lock semantics, and returns a response on a separate valid/ready channel.
- Drives flattened conf_addr/mode/perm/lock vectors continuously to the matcher array.

---
 rtl/iopmp_pkg.sv | 32 +++
 rtl/iopmp_cfg_legalize.sv | 23 ++
 rtl/iopmp_entry_cfg.sv | 146 ++++++++++++++
 tb/tb_iopmp_entry_cfg.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iopmp_pkg.sv
// Shared IOPMP types: address-match modes, the per-entry cfg register layout
// and the state encoding of the entry-table programming FSM.
package iopmp_pkg;

  typedef enum logic [1:0] {
    ADDR_MODE_OFF   = 2'd0,
    ADDR_MODE_TOR   = 2'd1,
    ADDR_MODE_NA4   = 2'd2,
    ADDR_MODE_NAPOT = 2'd3
  } iopmp_addr_mode_t;

  typedef struct packed {
    logic             locked;
    logic [1:0]       reserved;
    iopmp_addr_mode_t addr_mode;
    logic             x;
    logic             w;
    logic             r;
  } iopmp_cfg_t;

  localparam int CFG_R_BIT = 0;
  localparam int CFG_W_BIT = 1;
  localparam int CFG_X_BIT = 2;
  localparam int CFG_A_LSB = 3;
  localparam int CFG_L_BIT = 7;

  typedef enum logic {
    CFG_IDLE = 1'b0,
    CFG_RESP = 1'b1
  } iopmp_cfg_state_t;

endpackage

// File: rtl/iopmp_cfg_legalize.sv
// Turns a raw 8-bit cfg write into the value the entry table actually stores:
// reserved bits cleared, and write-only permission (W without R) dropped.
module iopmp_cfg_legalize
  import iopmp_pkg::*;
(
  input  logic [7:0] wdata_i,
  output iopmp_cfg_t cfg_o
);

  logic unused_reserved;
  assign unused_reserved = ^wdata_i[6:5];

  always_comb begin
    cfg_o           = '0;
    cfg_o.r         = wdata_i[CFG_R_BIT];
    cfg_o.w         = wdata_i[CFG_W_BIT] & wdata_i[CFG_R_BIT];
    cfg_o.x         = wdata_i[CFG_X_BIT];
    cfg_o.addr_mode = iopmp_addr_mode_t'(wdata_i[CFG_A_LSB +: 2]);
    cfg_o.reserved  = 2'b00;
    cfg_o.locked    = wdata_i[CFG_L_BIT];
  end

endmodule

// File: rtl/iopmp_entry_cfg.sv
// IOPMP entry-table register file: single-beat read/write requests in, one
// response out, with lock and TOR lower-bound protection on writes.
module iopmp_entry_cfg
  import iopmp_pkg::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int PMP_LEN     = 54,
  parameter int DATA_W      = 64,
  parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic                           req_we_i,
  input  logic                           req_sel_i,
  input  logic [IDX_W:0]                 req_idx_i,
  input  logic [DATA_W-1:0]              req_wdata_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [DATA_W-1:0]              rsp_rdata_o,
  output logic                           rsp_err_o,
  output logic [NUM_ENTRIES*PMP_LEN-1:0] conf_addr_o,
  output logic [NUM_ENTRIES*2-1:0]       conf_mode_o,
  output logic [NUM_ENTRIES*3-1:0]       conf_perm_o,
  output logic [NUM_ENTRIES-1:0]         conf_lock_o
);

  // Handshake: a request transfers on a rising edge where req_valid_i and
  // req_ready_o are both high; a response retires on an edge where
  // rsp_valid_o and rsp_ready_i are both high. Response payload is stable
  // while rsp_valid_o is high, and no new request is taken until it retires.

  localparam logic [IDX_W:0]   NUM_IDX  = (IDX_W+1)'(NUM_ENTRIES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  iopmp_cfg_state_t state_q, state_d;

  logic [PMP_LEN-1:0] addr_q [NUM_ENTRIES];
  iopmp_cfg_t         cfg_q  [NUM_ENTRIES];

  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  logic              accept;
  logic              idx_ok;
  logic [IDX_W-1:0]  sel_idx;
  logic [IDX_W-1:0]  nxt_idx;
  logic              tor_guard;
  logic              err;
  logic              do_write;
  iopmp_cfg_t        cur_cfg;
  iopmp_cfg_t        cfg_new;
  logic [7:0]        cur_cfg_bits;
  logic [7:0]        new_cfg_bits;
  logic [DATA_W-1:0] cur_val;
  logic [DATA_W-1:0] new_val;
  logic [DATA_W-1:0] rdata_d;

  logic unused_wdata;
  assign unused_wdata = ^req_wdata_i[DATA_W-1:PMP_LEN];

  iopmp_cfg_legalize u_legalize (
    .wdata_i (req_wdata_i[7:0]),
    .cfg_o   (cfg_new)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= CFG_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    accept      = 1'b0;
    unique case (state_q)
      CFG_IDLE: begin
        req_ready_o = 1'b1;
        accept      = req_valid_i;
        if (req_valid_i) state_d = CFG_RESP;
      end
      CFG_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = CFG_IDLE;
      end
      default: state_d = CFG_IDLE;
    endcase
  end

  // Out-of-range indices are steered to entry 0 so array reads stay in bounds;
  // the error path masks whatever that entry holds.
  always_comb begin
    idx_ok       = (req_idx_i < NUM_IDX);
    sel_idx      = idx_ok ? req_idx_i[IDX_W-1:0] : '0;
    nxt_idx      = (sel_idx != LAST_IDX) ? sel_idx + IDX_W'(1) : sel_idx;
    cur_cfg      = cfg_q[sel_idx];
    tor_guard    = (sel_idx != LAST_IDX) && cfg_q[nxt_idx].locked &&
                   (cfg_q[nxt_idx].addr_mode == ADDR_MODE_TOR);
    err          = !idx_ok ||
                   (req_we_i && (cur_cfg.locked || (!req_sel_i && tor_guard)));
    do_write     = accept && req_we_i && !err;
    cur_cfg_bits = cur_cfg;
    new_cfg_bits = cfg_new;
    cur_val      = req_sel_i ? DATA_W'(cur_cfg_bits) : DATA_W'(addr_q[sel_idx]);
    new_val      = req_sel_i ? DATA_W'(new_cfg_bits)
                             : DATA_W'(req_wdata_i[PMP_LEN-1:0]);
    if (!idx_ok)                rdata_d = '0;
    else if (req_we_i && !err)  rdata_d = new_val;
    else                        rdata_d = cur_val;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (accept) begin
      rsp_rdata_q <= rdata_d;
      rsp_err_q   <= err;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        addr_q[i] <= '0;
        cfg_q[i]  <= '0;
      end
    end else if (do_write) begin
      if (req_sel_i) cfg_q[sel_idx]  <= cfg_new;
      else           addr_q[sel_idx] <= req_wdata_i[PMP_LEN-1:0];
    end
  end

  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_conf
    assign conf_addr_o[g*PMP_LEN +: PMP_LEN] = addr_q[g];
    assign conf_mode_o[g*2 +: 2]             = cfg_q[g].addr_mode;
    assign conf_perm_o[g*3 +: 3]             = {cfg_q[g].x, cfg_q[g].w, cfg_q[g].r};
    assign conf_lock_o[g]                    = cfg_q[g].locked;
  end

endmodule

// File: tb/tb_iopmp_entry_cfg.sv
// Randomized bench for iopmp_entry_cfg: an entry-table model inside the bench
// predicts every response and the conf vectors, plus directed literal checks.
module tb_iopmp_entry_cfg;

  localparam int N       = 16;
  localparam int PMP_LEN = 54;
  localparam int DATA_W  = 64;
  localparam int IDX_W   = 4;
  localparam logic [63:0] ADDR_MASK = (64'd1 << PMP_LEN) - 64'd1;

  logic                      clk_i = 1'b0;
  logic                      rst_ni = 1'b0;
  logic                      req_valid_i = 1'b0;
  logic                      req_ready_o;
  logic                      req_we_i = 1'b0;
  logic                      req_sel_i = 1'b0;
  logic [IDX_W:0]            req_idx_i = '0;
  logic [DATA_W-1:0]         req_wdata_i = '0;
  logic                      rsp_valid_o;
  logic                      rsp_ready_i = 1'b0;
  logic [DATA_W-1:0]         rsp_rdata_o;
  logic                      rsp_err_o;
  logic [N*PMP_LEN-1:0]      conf_addr_o;
  logic [N*2-1:0]            conf_mode_o;
  logic [N*3-1:0]            conf_perm_o;
  logic [N-1:0]              conf_lock_o;

  iopmp_entry_cfg #(.NUM_ENTRIES(N), .PMP_LEN(PMP_LEN), .DATA_W(DATA_W)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_sel_i   (req_sel_i),
    .req_idx_i   (req_idx_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .conf_addr_o (conf_addr_o),
    .conf_mode_o (conf_mode_o),
    .conf_perm_o (conf_perm_o),
    .conf_lock_o (conf_lock_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- model + scoreboard ----------------
  int checks = 0;
  int failures = 0;

  logic [PMP_LEN-1:0] m_addr [N];
  logic [7:0]         m_cfg  [N];
  logic [DATA_W:0]    exp_q  [$];   // {err, rdata} of the outstanding response

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_addr[i] = '0;
      m_cfg[i]  = '0;
    end
  endfunction

  // Applies one request to the model table; returns the response it must give.
  function automatic void model_op(input logic we, input logic sel, input int idx,
                                   input logic [63:0] wd,
                                   output logic [63:0] rd, output logic er);
    logic [7:0] v;
    logic       blocked;
    if (idx >= N) begin
      rd = 64'd0;
      er = 1'b1;
      return;
    end
    blocked = m_cfg[idx][7] ||
              (!sel && idx < N-1 && m_cfg[idx+1][7] && m_cfg[idx+1][4:3] == 2'b01);
    er = we && blocked;
    if (we && !blocked) begin
      if (sel) begin
        v = wd[7:0];
        v[6:5] = 2'b00;
        if (!v[0]) v[1] = 1'b0;
        m_cfg[idx] = v;
      end else begin
        m_addr[idx] = wd[PMP_LEN-1:0];
      end
    end
    rd = sel ? {56'd0, m_cfg[idx]} : (64'(m_addr[idx]) & ADDR_MASK);
  endfunction

  // Compare process: conf vectors every cycle, handshake state and payload.
  always @(negedge clk_i) begin
    for (int i = 0; i < N; i++) begin
      check($sformatf("conf_addr[%0d]", i), conf_addr_o[i*PMP_LEN +: PMP_LEN], m_addr[i]);
      check($sformatf("conf_mode[%0d]", i), conf_mode_o[i*2 +: 2], m_cfg[i][4:3]);
      check($sformatf("conf_perm[%0d]", i), conf_perm_o[i*3 +: 3], m_cfg[i][2:0]);
      check($sformatf("conf_lock[%0d]", i), conf_lock_o[i], m_cfg[i][7]);
    end
    check("rsp_valid", rsp_valid_o, exp_q.size() > 0);
    check("req_ready", req_ready_o, exp_q.size() == 0);
    if (rsp_valid_o && exp_q.size() > 0)
      check("rsp_payload", {rsp_err_o, rsp_rdata_o}, exp_q[0]);
  end

  // ---------------- driver ----------------
  task automatic send(input logic we, input logic sel, input int idx,
                      input logic [63:0] wd, input int hold,
                      output logic [63:0] rd, output logic er);
    logic [63:0] mr;
    logic        me;
    int          n;
    rd = '0;
    er = 1'b0;
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_sel_i   = sel;
    req_idx_i   = idx[IDX_W:0];
    req_wdata_i = wd;
    n = 0;
    while (!req_ready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    if (!req_ready_o) begin
      check("accept_timeout", 1'b0, 1'b1);
      req_valid_i = 1'b0;
      return;
    end
    @(posedge clk_i);
    #1;
    model_op(we, sel, idx, wd, mr, me);
    exp_q.push_back({me, mr});
    // With hold > 0 the request stays presented to show it is not re-taken.
    if (hold == 0) req_valid_i = 1'b0;
    repeat (hold) @(negedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    rd = rsp_rdata_o;
    er = rsp_err_o;
    @(posedge clk_i);
    #1;
    rsp_ready_i = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] r;
    logic        e;
    int          idx;
    logic        we, sel;
    logic [63:0] wd;

    model_reset();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    check("reset_ready", req_ready_o, 1'b1);
    check("reset_valid", rsp_valid_o, 1'b0);
    check("reset_rdata", rsp_rdata_o, 64'd0);
    check("reset_err",   rsp_err_o, 1'b0);

    send(1'b0, 1'b1, 3, 64'd0, 0, r, e);
    check("rd_cfg3_data", r, 64'h00);
    check("rd_cfg3_err", e, 1'b0);
    check("modes_off", conf_mode_o, '0);

    send(1'b1, 1'b1, 2, 64'hFF, 0, r, e);
    check("wr_cfg2_data", r, 64'h9F);
    check("wr_cfg2_err", e, 1'b0);
    check("cfg2_mode_napot", conf_mode_o[5:4], 2'b11);
    check("cfg2_perm", conf_perm_o[8:6], 3'b111);
    check("cfg2_lock", conf_lock_o[2], 1'b1);

    send(1'b1, 1'b1, 2, 64'h00, 0, r, e);
    check("wr_locked_cfg2_err", e, 1'b1);
    check("wr_locked_cfg2_data", r, 64'h9F);

    send(1'b1, 1'b1, 5, 64'h0A, 0, r, e);
    check("wr_cfg5_wonly_data", r, 64'h08);
    check("cfg5_perm", conf_perm_o[17:15], 3'b000);

    send(1'b1, 1'b1, 5, 64'h89, 0, r, e);
    check("wr_cfg5_lock_data", r, 64'h89);
    send(1'b1, 1'b0, 4, 64'h1234, 0, r, e);
    check("tor_guard_err", e, 1'b1);
    check("tor_guard_data", r, 64'h0);
    check("tor_guard_addr4", conf_addr_o[4*PMP_LEN +: PMP_LEN], 54'h0);
    send(1'b1, 1'b0, 6, 64'h55, 0, r, e);
    check("wr_addr6_err", e, 1'b0);
    check("wr_addr6_data", r, 64'h55);

    send(1'b1, 1'b0, 7, 64'hFFFF_FFFF_FFFF_FFFF, 0, r, e);
    check("wr_addr7_trunc", r, 64'h003F_FFFF_FFFF_FFFF);
    check("wr_addr7_err", e, 1'b0);

    send(1'b0, 1'b1, 16, 64'd0, 0, r, e);
    check("rd_idx16_err", e, 1'b1);
    check("rd_idx16_data", r, 64'd0);
    send(1'b1, 1'b1, 31, 64'hFF, 0, r, e);
    check("wr_idx31_err", e, 1'b1);
    check("wr_idx31_data", r, 64'd0);

    send(1'b1, 1'b0, 8, 64'hABC, 5, r, e);
    check("stall_data", r, 64'hABC);
    send(1'b0, 1'b0, 8, 64'd0, 0, r, e);
    check("after_stall_read", r, 64'hABC);

    // Reset while a response is pending.
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_we_i    = 1'b0;
    req_sel_i   = 1'b1;
    req_idx_i   = 5'd2;
    @(posedge clk_i);
    #1;
    model_op(1'b0, 1'b1, 2, 64'd0, r, e);
    exp_q.push_back({e, r});
    req_valid_i = 1'b0;
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    model_reset();
    exp_q.delete();
    #1;
    check("rst_rsp_valid", rsp_valid_o, 1'b0);
    check("rst_req_ready", req_ready_o, 1'b1);
    check("rst_lock", conf_lock_o, '0);
    check("rst_addr_any", |conf_addr_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int k = 0; k < 250; k++) begin
      idx = $urandom_range(0, 18);
      if (idx == 18) idx = 31;
      we  = 1'($urandom_range(0, 1));
      sel = 1'($urandom_range(0, 1));
      wd  = {$urandom(), $urandom()};
      if (sel && we) wd[7] = ($urandom_range(0, 9) == 0);
      send(we, sel, idx, wd, $urandom_range(0, 3), r, e);
    end

    repeat (2) @(negedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
